// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline execution sequencer: state encoding,
// HALT opcode and default watchdog limit.
package pipeline_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFlush    = 3'd1,
    StRun      = 3'd2,
    StStepWait = 3'd3,
    StStepExec = 3'd4,
    StDone     = 3'd5
  } state_e;

  localparam logic [5:0]  HALT_OPCODE        = 6'b111111;
  localparam int unsigned WDT_CYCLES_DEFAULT = 1024;

  function automatic logic state_is_busy(state_e s);
    return (s == StFlush) || (s == StRun) || (s == StStepWait) || (s == StStepExec);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Command/status bundle between the debug unit (master) and the sequencer (slave).
interface pipeline_exec_ctrl_if #(
  parameter int unsigned CNTBITS = 32
);
  logic               i_Start;
  logic               i_ModoPaso;
  logic               i_Step;
  logic               i_Abort;
  logic               i_HaltWB;
  logic               o_PipeEnable;
  logic               o_PipeFlush;
  logic               o_Busy;
  logic               o_Done;
  logic               o_Timeout;
  logic [CNTBITS-1:0] o_CycleCount;
  logic [CNTBITS-1:0] o_StepCount;

  modport master (
    output i_Start, i_ModoPaso, i_Step, i_Abort, i_HaltWB,
    input  o_PipeEnable, o_PipeFlush, o_Busy, o_Done, o_Timeout, o_CycleCount, o_StepCount
  );

  modport slave (
    input  i_Start, i_ModoPaso, i_Step, i_Abort, i_HaltWB,
    output o_PipeEnable, o_PipeFlush, o_Busy, o_Done, o_Timeout, o_CycleCount, o_StepCount
  );
endinterface

// File: rtl/exec_counter.sv
// Wrapping up-counter with synchronous clear (clear wins over increment).
module exec_counter #(
  parameter int unsigned CNTBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_incr,
  output logic [CNTBITS-1:0] o_count
);

  logic [CNTBITS-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/single-step sequencer for the 5-stage pipeline: drives enable/flush,
// stops on HALT in MEM/WB, abort or watchdog, and counts cycles and steps.
module pipeline_exec_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNTBITS    = 32,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
  input logic                 i_clk,
  input logic                 i_reset,
  pipeline_exec_ctrl_if.slave bus
);

  localparam logic [CNTBITS-1:0] WdtLimit = CNTBITS'(WDT_CYCLES);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_mode;
  logic               r_timeout;
  logic               w_wdt_hit;
  logic               w_enable;
  logic               w_flush;
  logic               w_step_incr;
  logic [CNTBITS-1:0] w_cycle_count;
  logic [CNTBITS-1:0] w_step_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (bus.i_Start) w_state_next = StFlush;
      StFlush:    w_state_next = r_mode ? StStepWait : StRun;
      StRun:      if (bus.i_Abort || bus.i_HaltWB || w_wdt_hit) w_state_next = StDone;
      StStepWait: begin
        if (bus.i_Abort) begin
          w_state_next = StDone;
        end else if (bus.i_Step) begin
          w_state_next = StStepExec;
        end
      end
      StStepExec: w_state_next = (bus.i_Abort || bus.i_HaltWB) ? StDone : StStepWait;
      StDone:     if (bus.i_Start) w_state_next = StFlush;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_wdt_hit   = (r_state == StRun) && (w_cycle_count == WdtLimit);
    w_enable    = ((r_state == StRun) || (r_state == StStepExec)) &&
                  !bus.i_HaltWB && !bus.i_Abort && !w_wdt_hit;
    w_flush     = (r_state == StFlush);
    w_step_incr = w_enable && (r_state == StStepExec);
  end

  // Mode is latched only when a start is accepted; timeout is set only when the
  // watchdog is the winning exit reason (abort/halt take precedence).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (((r_state == StIdle) || (r_state == StDone)) && bus.i_Start) begin
        r_mode <= bus.i_ModoPaso;
      end
      if (w_flush) begin
        r_timeout <= 1'b0;
      end else if (w_wdt_hit && !bus.i_Abort && !bus.i_HaltWB) begin
        r_timeout <= 1'b1;
      end
    end
  end

  exec_counter #(.CNTBITS(CNTBITS)) u_cycle_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_flush),
    .i_incr  (w_enable),
    .o_count (w_cycle_count)
  );

  exec_counter #(.CNTBITS(CNTBITS)) u_step_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_flush),
    .i_incr  (w_step_incr),
    .o_count (w_step_count)
  );

  assign bus.o_PipeEnable = w_enable;
  assign bus.o_PipeFlush  = w_flush;
  assign bus.o_Busy       = state_is_busy(r_state);
  assign bus.o_Done       = (r_state == StDone);
  assign bus.o_Timeout    = r_timeout;
  assign bus.o_CycleCount = w_cycle_count;
  assign bus.o_StepCount  = w_step_count;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl with a 16-cycle watchdog.
module tb_pipeline_exec_ctrl;

  localparam int unsigned CNTBITS = 32;
  localparam int unsigned WDT     = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 i_clk = ~i_clk;

  pipeline_exec_ctrl_if #(.CNTBITS(CNTBITS)) bus ();

  pipeline_exec_ctrl #(
    .CNTBITS    (CNTBITS),
    .WDT_CYCLES (WDT)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // Stimulus changes at posedge+1, sampling at the following negedge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_reset        = 1'b1;
    bus.i_Start    = 1'b0;
    bus.i_ModoPaso = 1'b0;
    bus.i_Step     = 1'b0;
    bus.i_Abort    = 1'b0;
    bus.i_HaltWB   = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b0;
  endtask

  task automatic start_cmd(input logic mode);
    bus.i_ModoPaso = mode;
    bus.i_Start    = 1'b1;
    cyc();
    bus.i_Start    = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    apply_reset();
    mid();
    flags = {bus.o_PipeEnable, bus.o_PipeFlush, bus.o_Busy, bus.o_Done, bus.o_Timeout};
    n_checks++;
    if (flags !== 5'b0) begin
      n_fail++;
      $display("FAIL reset.flags got %b want 00000", flags);
    end
    n_checks++;
    if (bus.o_CycleCount !== 32'd0 || bus.o_StepCount !== 32'd0) begin
      n_fail++;
      $display("FAIL reset.counts got %0d/%0d want 0/0", bus.o_CycleCount, bus.o_StepCount);
    end
    cyc();
  endtask

  task automatic test_run_halt();
    int flush_cnt = 0;
    int en_cnt    = 0;
    apply_reset();
    start_cmd(1'b0);
    mid();
    if (bus.o_PipeFlush) flush_cnt++;
    n_checks++;
    if (bus.o_PipeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halt.flush_en got %b want 0", bus.o_PipeEnable);
    end
    cyc();
    for (int i = 1; i <= 10; i++) begin
      bus.i_HaltWB = (i == 10);
      mid();
      if (bus.o_PipeEnable) en_cnt++;
      if (bus.o_PipeFlush) flush_cnt++;
      if (i == 10) begin
        n_checks++;
        if (bus.o_PipeEnable !== 1'b0) begin
          n_fail++;
          $display("FAIL run_halt.halt_en got %b want 0", bus.o_PipeEnable);
        end
      end
      cyc();
    end
    bus.i_HaltWB = 1'b0;
    mid();
    n_checks++;
    if (flush_cnt != 1) begin
      n_fail++;
      $display("FAIL run_halt.flush_cycles got %0d want 1", flush_cnt);
    end
    n_checks++;
    if (en_cnt != 9) begin
      n_fail++;
      $display("FAIL run_halt.en_cycles got %0d want 9", en_cnt);
    end
    n_checks++;
    if (bus.o_Done !== 1'b1 || bus.o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halt.done got done=%b busy=%b want 1/0", bus.o_Done, bus.o_Busy);
    end
    n_checks++;
    if (bus.o_CycleCount !== 32'd9 || bus.o_StepCount !== 32'd0) begin
      n_fail++;
      $display("FAIL run_halt.counts got %0d/%0d want 9/0", bus.o_CycleCount, bus.o_StepCount);
    end
    cyc();
  endtask

  task automatic test_single_step();
    int   pulses = 0;
    int   en_cnt = 0;
    logic prev   = 1'b0;
    apply_reset();
    start_cmd(1'b1);
    mid();
    cyc();
    for (int i = 0; i < 16; i++) begin
      bus.i_Step = (i == 0) || (i == 5) || (i == 10);
      mid();
      if (bus.o_PipeEnable) en_cnt++;
      if (bus.o_PipeEnable && !prev) pulses++;
      prev = bus.o_PipeEnable;
      cyc();
    end
    bus.i_Step = 1'b0;
    mid();
    n_checks++;
    if (pulses != 3 || en_cnt != 3) begin
      n_fail++;
      $display("FAIL step.pulses got %0d pulses/%0d cycles want 3/3", pulses, en_cnt);
    end
    n_checks++;
    if (bus.o_StepCount !== 32'd3 || bus.o_CycleCount !== 32'd3) begin
      n_fail++;
      $display("FAIL step.counts got %0d/%0d want 3/3", bus.o_StepCount, bus.o_CycleCount);
    end
    n_checks++;
    if (bus.o_Busy !== 1'b1 || bus.o_Done !== 1'b0 || bus.o_PipeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL step.wait got busy=%b done=%b en=%b want 1/0/0",
               bus.o_Busy, bus.o_Done, bus.o_PipeEnable);
    end
    cyc();
  endtask

  // Continues from STEP_WAIT left by test_single_step.
  task automatic test_priority();
    bus.i_Step  = 1'b1;
    bus.i_Abort = 1'b1;
    mid();
    n_checks++;
    if (bus.o_PipeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL prio.abort_en got %b want 0", bus.o_PipeEnable);
    end
    cyc();
    bus.i_Step  = 1'b0;
    bus.i_Abort = 1'b0;
    mid();
    n_checks++;
    if (bus.o_Done !== 1'b1 || bus.o_StepCount !== 32'd3 || bus.o_PipeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL prio.abort_done got done=%b steps=%0d en=%b want 1/3/0",
               bus.o_Done, bus.o_StepCount, bus.o_PipeEnable);
    end
    cyc();
    start_cmd(1'b1);
    mid();
    cyc();
    bus.i_Step = 1'b1;
    cyc();
    bus.i_Step   = 1'b0;
    bus.i_HaltWB = 1'b1;
    mid();
    n_checks++;
    if (bus.o_PipeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL prio.halt_exec_en got %b want 0", bus.o_PipeEnable);
    end
    cyc();
    bus.i_HaltWB = 1'b0;
    mid();
    n_checks++;
    if (bus.o_Done !== 1'b1 || bus.o_StepCount !== 32'd0 || bus.o_CycleCount !== 32'd0) begin
      n_fail++;
      $display("FAIL prio.halt_exec_done got done=%b steps=%0d cycles=%0d want 1/0/0",
               bus.o_Done, bus.o_StepCount, bus.o_CycleCount);
    end
    cyc();
  endtask

  task automatic test_watchdog();
    int   en_cnt = 0;
    logic got    = 1'b0;
    apply_reset();
    start_cmd(1'b0);
    mid();
    cyc();
    for (int i = 0; i < 40; i++) begin
      mid();
      if (bus.o_Done) begin
        got = 1'b1;
        break;
      end
      if (bus.o_PipeEnable) en_cnt++;
      cyc();
    end
    n_checks++;
    if (got !== 1'b1 || en_cnt != 16) begin
      n_fail++;
      $display("FAIL wdt.stop got done=%b en_cycles=%0d want 1/16", got, en_cnt);
    end
    n_checks++;
    if (bus.o_Timeout !== 1'b1 || bus.o_CycleCount !== 32'd16) begin
      n_fail++;
      $display("FAIL wdt.flag got timeout=%b cycles=%0d want 1/16",
               bus.o_Timeout, bus.o_CycleCount);
    end
    cyc();
    start_cmd(1'b0);
    mid();
    cyc();
    mid();
    n_checks++;
    if (bus.o_Timeout !== 1'b0 || bus.o_CycleCount !== 32'd0 || bus.o_StepCount !== 32'd0 ||
        bus.o_PipeEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL wdt.restart got timeout=%b cycles=%0d steps=%0d en=%b want 0/0/0/1",
               bus.o_Timeout, bus.o_CycleCount, bus.o_StepCount, bus.o_PipeEnable);
    end
    cyc();
    bus.i_Abort = 1'b1;
    cyc();
    bus.i_Abort = 1'b0;
    mid();
    n_checks++;
    if (bus.o_Done !== 1'b1 || bus.o_Timeout !== 1'b0 || bus.o_CycleCount !== 32'd1) begin
      n_fail++;
      $display("FAIL wdt.abort got done=%b timeout=%b cycles=%0d want 1/0/1",
               bus.o_Done, bus.o_Timeout, bus.o_CycleCount);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    apply_reset();
    start_cmd(1'b0);
    mid();
    cyc();
    repeat (4) cyc();
    mid();
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (bus.o_PipeEnable !== 1'b0 || bus.o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset.immediate got en=%b busy=%b want 0/0", bus.o_PipeEnable, bus.o_Busy);
    end
    cyc();
    n_checks++;
    if (bus.o_CycleCount !== 32'd0 || bus.o_StepCount !== 32'd0 || bus.o_Done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset.counts got %0d/%0d done=%b want 0/0/0",
               bus.o_CycleCount, bus.o_StepCount, bus.o_Done);
    end
    i_reset = 1'b0;
    mid();
    n_checks++;
    if (bus.o_PipeEnable !== 1'b0 || bus.o_Busy !== 1'b0 || bus.o_PipeFlush !== 1'b0) begin
      n_fail++;
      $display("FAIL areset.idle got en=%b busy=%b flush=%b want 0/0/0",
               bus.o_PipeEnable, bus.o_Busy, bus.o_PipeFlush);
    end
    cyc();
  endtask

  task automatic test_ignored_start();
    logic ok = 1'b1;
    apply_reset();
    start_cmd(1'b0);
    mid();
    cyc();
    repeat (3) cyc();
    bus.i_Start    = 1'b1;
    bus.i_ModoPaso = 1'b1;
    mid();
    n_checks++;
    if (bus.o_PipeFlush !== 1'b0 || bus.o_PipeEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_start.pulse got flush=%b en=%b want 0/1",
               bus.o_PipeFlush, bus.o_PipeEnable);
    end
    cyc();
    bus.i_Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (bus.o_PipeEnable !== 1'b1 || bus.o_PipeFlush !== 1'b0) ok = 1'b0;
      cyc();
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_start.continue got ok=%b want 1", ok);
    end
    bus.i_Abort = 1'b1;
    cyc();
    bus.i_Abort = 1'b0;
    mid();
    n_checks++;
    if (bus.o_Done !== 1'b1 || bus.o_CycleCount !== 32'd8 || bus.o_StepCount !== 32'd0) begin
      n_fail++;
      $display("FAIL ign_start.counts got done=%b cycles=%0d steps=%0d want 1/8/0",
               bus.o_Done, bus.o_CycleCount, bus.o_StepCount);
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_run_halt();
    test_single_step();
    test_priority();
    test_watchdog();
    test_async_reset();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
- Execution sequencer for the 5-stage MIPS pipeline. It drives the global enable and synchronous flush of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- It supports continuous run and single-step modes, under command of the debug unit.
- It stops the pipeline when a HALT instruction reaches the MEM/WB register, or when a watchdog cycle limit is reached. It reports cycle and step counts back to the debug unit.

Parameters:
- CNTBITS, 32, width of the cycle and step counters.
- WDT_CYCLES, 1024, maximum number of enabled cycles in RUN before a forced stop. Legal range is 1 to 2^CNTBITS-1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_Start  in  1  start command, sampled in IDLE and DONE.
- i_ModoPaso  in  1  mode select, sampled with i_Start: 1 = single-step, 0 = continuous.
- i_Step  in  1  step command, sampled only in STEP_WAIT.
- i_Abort  in  1  debug abort.
- i_HaltWB  in  1  HALT opcode decoded from the MEM/WB instruction output.
- o_PipeEnable  out  1  enable for the PC and all pipeline registers.
- o_PipeFlush  out  1  synchronous clear of the PC and all pipeline registers.
- o_Busy  out  1  high in FLUSH, RUN, STEP_WAIT and STEP_EXEC.
- o_Done  out  1  high in DONE.
- o_Timeout  out  1  sticky watchdog flag.
- o_CycleCount  out  CNTBITS  number of enabled pipeline cycles.
- o_StepCount  out  CNTBITS  number of completed single steps.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high; asserting it, including mid-run, forces IDLE immediately.
- Reset values: state=IDLE; o_PipeEnable=0, o_PipeFlush=0, o_Busy=0, o_Done=0, o_Timeout=0; both counters=0.
- Output timing: all outputs are Moore/registered except o_PipeEnable. o_PipeEnable = (state==RUN or state==STEP_EXEC) AND NOT i_HaltWB AND NOT i_Abort AND NOT wdt_hit, where wdt_hit = (state==RUN and o_CycleCount==WDT_CYCLES).
- IDLE: enable=0. On i_Start, go to FLUSH and latch i_ModoPaso internally as mode.
- FLUSH: lasts exactly 1 cycle, with o_PipeFlush=1 and enable=0.
  - Clears both counters and o_Timeout.
  - Next state is RUN if mode=0, else STEP_WAIT.
- RUN: o_PipeEnable=1 and o_CycleCount+1 each cycle. Exit rules, first match wins:
  - i_Abort: go to DONE.
  - i_HaltWB: go to DONE.
  - wdt_hit: go to DONE and set o_Timeout=1.
  - On any exit cycle, enable=0 and the counter is not incremented.
- STEP_WAIT: enable=0. On i_Step, go to STEP_EXEC. On i_Abort, go to DONE (abort takes priority over i_Step).
- STEP_EXEC: lasts exactly 1 cycle. Normally enable=1, CycleCount+1, StepCount+1, then back to STEP_WAIT. Exceptions:
  - If i_HaltWB or i_Abort is high, enable=0, counters hold, go to DONE.
  - The watchdog does not apply in step mode.
- Step pacing: i_Step held high produces one step every 2 cycles. The debug unit must pulse it for one cycle per step.
- DONE: o_Done=1, enable=0, counters and o_Timeout hold. On i_Start, go to FLUSH (restart, mode re-latched).
- Ignored inputs:
  - i_Start is ignored in FLUSH, RUN, STEP_WAIT and STEP_EXEC.
  - i_Step is ignored outside STEP_WAIT.
  - i_Abort is ignored in IDLE, FLUSH and DONE.
- Counter wrap: counters wrap modulo 2^CNTBITS; no saturation. In RUN the watchdog always triggers first.
- i_HaltWB during FLUSH is ignored, because the pipeline is being cleared.

Decomposition:
- Shared package (pipeline_pkg):
  - 3-bit state encoding localparams: IDLE=0, FLUSH=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DONE=5.
  - HALT opcode constant.
  - Default WDT_CYCLES.
- Sub-module exec_counter: a CNTBITS-wide counter with clear/increment inputs, instantiated twice (cycle and step counters).
- The FSM and the enable gating stay in the top module.

Test Plan:
- Run and halt: reset, then i_Start=1 for 1 cycle with i_ModoPaso=0. Raise i_HaltWB in the 10th RUN cycle.
  - Expect o_PipeFlush=1 for exactly 1 cycle.
  - Expect o_PipeEnable=1 for 9 cycles and 0 in the halt cycle.
  - Expect o_Done=1, o_CycleCount=9, o_StepCount=0.
- Single-step: start with i_ModoPaso=1, then issue three 1-cycle i_Step pulses 5 cycles apart.
  - Expect exactly three 1-cycle o_PipeEnable pulses.
  - Expect o_StepCount=3, o_CycleCount=3, state STEP_WAIT.
- Watchdog: WDT_CYCLES=16, continuous run, i_HaltWB never asserted.
  - Expect DONE after 16 enabled cycles, with o_Timeout=1 and o_CycleCount=16.
  - Then i_Start clears o_Timeout and the counts to 0.
- Priority: in STEP_WAIT, assert i_Step and i_Abort in the same cycle.
  - Expect DONE, no enable pulse, o_StepCount unchanged.
  - Separately, in STEP_EXEC with i_HaltWB=1: expect enable=0 and DONE.
- Async reset mid-run: assert i_reset between clock edges during RUN.
  - Expect o_PipeEnable=0 immediately, state IDLE, and both counters 0 at the next edge.
- Ignored start: pulse i_Start during RUN with i_ModoPaso=1.
  - Expect no flush, mode unchanged, counting continues.
